// File: rtl/xgmii_rx_tlp_framer.sv
// Drains the XGMII-RX FIFO into a 64-bit AXI4-Stream TLP interface, dropping gap words,
// tagging tkeep/tlast and truncating TLPs that exceed MAX_BEATS.
module xgmii_rx_tlp_framer #(
  parameter logic [9:0] MAX_BEATS = 10'd130,
  parameter logic       BYTE_SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  output logic [63:0] s_axis_tx_tdata,
  output logic [7:0]  s_axis_tx_tkeep,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  output logic [15:0] tlp_count,
  output logic [7:0]  trunc_count,
  output logic        busy
);

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned KEEP_W  = 8;
  localparam int unsigned BEAT_W  = 10;
  localparam int unsigned TLP_CW  = 16;
  localparam int unsigned TRUNC_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, nxt_beat;
  beat_t             head_q, skid_q, new_beat;
  logic              head_vld, skid_vld;
  logic              run_q, rd_inflight;
  logic              push, pop, trunc;
  logic [1:0]        occ_eff;
  logic              unused_bits;

  function automatic logic [DATA_W-1:0] dw_swap(input logic [DATA_W-1:0] d);
    return {d[39:32], d[47:40], d[55:48], d[63:56], d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign unused_bits = ^{dout[71:68], dout[66]};

  // Occupancy after this cycle's pop; a read issued now lands in the buffer next cycle.
  assign pop     = head_vld & s_axis_tx_tready;
  assign occ_eff = 2'(head_vld) + 2'(skid_vld) - 2'(pop);
  assign rd_en   = run_q & ~empty & ((occ_eff + 2'(rd_inflight)) < 2'd2);

  assign s_axis_tx_tdata  = head_q.data;
  assign s_axis_tx_tkeep  = head_q.keep;
  assign s_axis_tx_tlast  = head_q.last;
  assign s_axis_tx_tvalid = head_vld;

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      busy    <= (state_d != IDLE);
    end
  end

  // Framing decisions for the word returned by the FIFO this cycle
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    push          = 1'b0;
    trunc         = 1'b0;
    nxt_beat      = (state_q == IDLE) ? BEAT_W'(1) : beat_q + BEAT_W'(1);
    new_beat.data = BYTE_SWAP ? dw_swap(dout[63:0]) : dout[63:0];
    new_beat.keep = dout[67] ? 8'hFF : 8'h0F;
    new_beat.last = dout[65];
    if (rd_inflight && dout[64]) begin
      unique case (state_q)
        IDLE, DATA: begin
          push   = 1'b1;
          beat_d = nxt_beat;
          if (dout[65]) begin
            state_d = IDLE;
          end else if (nxt_beat >= MAX_BEATS) begin
            trunc         = 1'b1;
            new_beat.last = 1'b1;
            state_d       = DROP;
          end else begin
            state_d = DATA;
          end
        end
        DROP: if (dout[65]) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry skid buffer (head drives the stream) plus counters
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_q       <= 1'b0;
      rd_inflight <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      head_vld    <= 1'b0;
      skid_vld    <= 1'b0;
      tlp_count   <= '0;
      trunc_count <= '0;
    end else begin
      run_q       <= 1'b1;
      rd_inflight <= rd_en;
      if (trunc && trunc_count != 8'hFF) trunc_count <= trunc_count + TRUNC_W'(1);
      if (pop && head_q.last) tlp_count <= tlp_count + TLP_CW'(1);
      if (pop) begin
        if (skid_vld) begin
          head_q <= skid_q;
          if (push) skid_q <= new_beat;
          else skid_vld <= 1'b0;
        end else if (push) begin
          head_q <= new_beat;
        end else begin
          head_vld <= 1'b0;
        end
      end else if (!head_vld) begin
        if (push) begin
          head_q   <= new_beat;
          head_vld <= 1'b1;
        end
      end else if (push) begin
        skid_q   <= new_beat;
        skid_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xgmii_rx_tlp_framer.sv
// Scoreboard bench: two framer instances (default and MAX_BEATS=4/BYTE_SWAP=1) fed from
// queue-modelled standard FIFOs; a negedge monitor checks every presented beat.
module tb_xgmii_rx_tlp_framer;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tready = 1'b1;
  logic [71:0] dout0 = '0, dout1 = '0;
  logic        empty0 = 1'b1, empty1 = 1'b1;
  logic        rd_en0, rd_en1;
  logic [63:0] tdata0, tdata1;
  logic [7:0]  tkeep0, tkeep1;
  logic        tlast0, tlast1, tvalid0, tvalid1, busy0, busy1;
  logic [15:0] tlp_count0, tlp_count1;
  logic [7:0]  trunc_count0, trunc_count1;

  logic [72:0] fifo0[$], fifo1[$];
  exp_t        exp0[$], exp1[$];
  int          n_vec = 0, n_bad = 0;
  int          cyc = 0, rd_cyc = 0, live0 = 0;
  bit          lat_arm = 0, lat_got = 0, t1_on = 0, chk_live = 0;
  int          t1_n = 0;
  int          hs_cyc[3];

  always #5 clk = ~clk;

  xgmii_rx_tlp_framer u_dut0 (
    .clk(clk), .sys_rst_n(rst_n), .dout(dout0), .empty(empty0), .rd_en(rd_en0),
    .s_axis_tx_tdata(tdata0), .s_axis_tx_tkeep(tkeep0), .s_axis_tx_tlast(tlast0),
    .s_axis_tx_tvalid(tvalid0), .s_axis_tx_tready(tready),
    .tlp_count(tlp_count0), .trunc_count(trunc_count0), .busy(busy0)
  );

  xgmii_rx_tlp_framer #(.MAX_BEATS(10'd4), .BYTE_SWAP(1'b1)) u_dut1 (
    .clk(clk), .sys_rst_n(rst_n), .dout(dout1), .empty(empty1), .rd_en(rd_en1),
    .s_axis_tx_tdata(tdata1), .s_axis_tx_tkeep(tkeep1), .s_axis_tx_tlast(tlast1),
    .s_axis_tx_tvalid(tvalid1), .s_axis_tx_tready(tready),
    .tlp_count(tlp_count1), .trunc_count(trunc_count1), .busy(busy1)
  );

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // ctl = {dout[67], dout[66], dout[65], dout[64]}; app = word should reach the stream
  task automatic put(input int inst, input logic [3:0] ctl, input logic [63:0] d, input bit app,
                     input logic [63:0] ed, input logic [7:0] ek, input bit el);
    logic [72:0] w;
    exp_t        e;
    w = {app, 4'h0, ctl, d};
    e = '{d: ed, k: ek, l: el};
    if (inst == 0) begin
      fifo0.push_back(w);
      if (app) exp0.push_back(e);
    end else begin
      fifo1.push_back(w);
      if (app) exp1.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit toggle);
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || fifo0.size() != 0 || fifo1.size() != 0)
           && n < 2000) begin
      step();
      if (toggle) tready = ~tready;
      n++;
    end
    tready = 1'b1;
    check("drain_timeout", 80'(n >= 2000), 80'(0));
    if (n >= 2000) begin
      exp0.delete();
      exp1.delete();
    end
    repeat (4) step();
  endtask

  // Standard (non-FWFT) FIFO models: data one cycle after rd_en
  always @(posedge clk) begin
    logic [72:0] w0, w1;
    cyc <= cyc + 1;
    if (rd_en0 && fifo0.size() > 0) begin
      w0 = fifo0.pop_front();
      dout0 <= w0[71:0];
      if (w0[72]) live0 = live0 + 1;
      if (lat_arm && !lat_got) begin
        rd_cyc  = cyc;
        lat_got = 1;
      end
    end
    if (rd_en1 && fifo1.size() > 0) begin
      w1 = fifo1.pop_front();
      dout1 <= w1[71:0];
    end
    if (tvalid0 && tready) live0 = live0 - 1;
    empty0 <= (fifo0.size() == 0);
    empty1 <= (fifo1.size() == 0);
  end

  // Monitor: every presented beat (held or accepted) must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid0) begin
        if (exp0.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL beat0_extra: got %h/%h/%b want none", tdata0, tkeep0, tlast0);
        end else begin
          check("beat0", {7'd0, tdata0, tkeep0, tlast0}, {7'd0, exp0[0]});
          if (tready) void'(exp0.pop_front());
        end
        if (lat_arm && lat_got) begin
          check("first_tvalid_latency", 80'(cyc - rd_cyc), 80'(2));
          lat_arm = 0;
        end
        if (t1_on && tready && t1_n < 3) begin
          hs_cyc[t1_n] = cyc;
          t1_n++;
        end
      end
      if (tvalid1) begin
        if (exp1.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL beat1_extra: got %h/%h/%b want none", tdata1, tkeep1, tlast1);
        end else begin
          check("beat1", {7'd0, tdata1, tkeep1, tlast1}, {7'd0, exp1[0]});
          if (tready) void'(exp1.pop_front());
        end
      end
      if (chk_live) check("buffered_plus_inflight_le2", 80'(live0 > 2), 80'(0));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_rd_en", 80'(rd_en0), 80'(0));
    check("rst_tvalid", 80'(tvalid0), 80'(0));
    check("rst_tdata_tkeep_tlast", {7'd0, tdata0, tkeep0, tlast0}, 80'(0));
    check("rst_counters", {56'd0, tlp_count0, trunc_count1}, 80'(0));
    check("rst_busy", 80'({busy0, busy1}), 80'(0));
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // 3-beat TLP at full rate
    lat_arm = 1; t1_on = 1;
    put(0, 4'b1101, 64'h1111_0000_0000_0001, 1, 64'h1111_0000_0000_0001, 8'hFF, 0);
    put(0, 4'b1101, 64'h1111_0000_0000_0002, 1, 64'h1111_0000_0000_0002, 8'hFF, 0);
    put(0, 4'b1111, 64'h1111_0000_0000_0003, 1, 64'h1111_0000_0000_0003, 8'hFF, 1);
    drain(0);
    t1_on = 0;
    check("t1_latency_seen", 80'(lat_arm), 80'(0));
    check("t1_beats_seen", 80'(t1_n), 80'(3));
    check("t1_consecutive", 80'(hs_cyc[2] - hs_cyc[0]), 80'(2));
    check("t1_tlp_count", 80'(tlp_count0), 80'(1));
    check("t1_busy", 80'(busy0), 80'(0));

    // 1DW-ending TLP, gap words, 1-beat TLP, illegal low-DW-disable entry
    put(0, 4'b1101, 64'h2222_0000_0000_000A, 1, 64'h2222_0000_0000_000A, 8'hFF, 0);
    put(0, 4'b0111, 64'h2222_0000_0000_000B, 1, 64'h2222_0000_0000_000B, 8'h0F, 1);
    for (int i = 0; i < 5; i++) put(0, 4'b0000, 64'hDEAD_BEEF_0000_0000, 0, '0, '0, 0);
    put(0, 4'b1111, 64'h2222_0000_0000_000C, 1, 64'h2222_0000_0000_000C, 8'hFF, 1);
    put(0, 4'b0011, 64'h2222_0000_0000_000D, 1, 64'h2222_0000_0000_000D, 8'h0F, 1);
    drain(0);
    check("t2_tlp_count", 80'(tlp_count0), 80'(4));

    // 10-beat TLP with tready toggling every cycle
    chk_live = 1;
    for (int i = 0; i < 10; i++)
      put(0, (i == 9) ? 4'b1111 : 4'b1101, 64'hA5A5_0000_0000_0000 | 64'(i), 1,
          64'hA5A5_0000_0000_0000 | 64'(i), 8'hFF, i == 9);
    drain(1);
    chk_live = 0;
    check("t3_tlp_count", 80'(tlp_count0), 80'(5));
    check("t3_trunc_count", 80'(trunc_count0), 80'(0));

    // MAX_BEATS=4: 6-beat TLP truncated after beat 4, then an intact 2-beat TLP (swapped DWs)
    put(1, 4'b1101, 64'h00000010_00000011, 1, 64'h10000000_11000000, 8'hFF, 0);
    put(1, 4'b1101, 64'h00000020_00000021, 1, 64'h20000000_21000000, 8'hFF, 0);
    put(1, 4'b1101, 64'h00000030_00000031, 1, 64'h30000000_31000000, 8'hFF, 0);
    put(1, 4'b1101, 64'h00000040_00000041, 1, 64'h40000000_41000000, 8'hFF, 1);
    put(1, 4'b1101, 64'h00000050_00000051, 0, '0, '0, 0);
    put(1, 4'b1111, 64'h00000060_00000061, 0, '0, '0, 0);
    put(1, 4'b1101, 64'h00000070_00000071, 1, 64'h70000000_71000000, 8'hFF, 0);
    put(1, 4'b1111, 64'h00000080_00000081, 1, 64'h80000000_81000000, 8'hFF, 1);
    drain(0);
    check("t4_trunc_count", 80'(trunc_count1), 80'(1));
    check("t4_tlp_count", 80'(tlp_count1), 80'(2));
    check("t4_busy", 80'(busy1), 80'(0));

    // Byte swap within each DW
    put(1, 4'b1111, 64'h0011223344556677, 1, 64'h3322110077665544, 8'hFF, 1);
    put(1, 4'b0111, 64'h8899AABBCCDDEEFF, 1, 64'hBBAA9988FFEEDDCC, 8'h0F, 1);
    drain(0);
    check("t5_tlp_count", 80'(tlp_count1), 80'(4));

    // Async reset mid-TLP while streaming
    for (int i = 0; i < 20; i++)
      put(0, 4'b1101, 64'h6666_0000_0000_0000 | 64'(i), 1, 64'h6666_0000_0000_0000 | 64'(i),
          8'hFF, 0);
    n = 0;
    while (exp0.size() > 14 && n < 100) begin
      step();
      n++;
    end
    check("t6_stream_started", 80'(n >= 100), 80'(0));
    check("t6_pre_rd_en", 80'({tvalid0, rd_en0}), 80'(2'b11));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tvalid", 80'(tvalid0), 80'(0));
    check("t6_rst_rd_en", 80'(rd_en0), 80'(0));
    check("t6_rst_counters", {48'd0, tlp_count0, trunc_count1, tlp_count1}, 80'(0));
    check("t6_rst_busy", 80'(busy0), 80'(0));
    fifo0.delete();
    exp0.delete();
    live0 = 0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    put(0, 4'b1101, 64'h7777_0000_0000_0001, 1, 64'h7777_0000_0000_0001, 8'hFF, 0);
    put(0, 4'b0111, 64'h7777_0000_0000_0002, 1, 64'h7777_0000_0000_0002, 8'h0F, 1);
    drain(0);
    check("t6_post_tlp_count", 80'(tlp_count0), 80'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
